data_mem_responder: RTL and testbench

- Multi-cycle data-memory responder: the target end of the pipeline's load/store interface.
- Accepts one request at a time over a valid/ready handshake and inserts a configurable number of wait states.
- Performs byte/half/word stores and sign/zero-extended loads selected by Funct3, then returns a response over a second valid/ready handshake.
- Replaces the single-cycle data memory when the pipeline is extended to stall on memory.

---
 rtl/mem_pkg.sv | 46 ++++
 rtl/data_mem_responder_if.sv | 38 +++
 rtl/load_store_align.sv | 73 +++++++
 rtl/data_mem_responder.sv | 168 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
//   Shared definitions for the data-memory responder:
//   - Funct3 access-size/sign constants (RISC-V load/store encoding)
//   - Responder FSM state enum
//   - Latched request record
//   - Helper that maps a Funct3 size field to a byte-enable mask
// -----------------------------------------------------------------------------
package mem_pkg;

  // Funct3 encodings. Bits [1:0] give the access size (byte/half/word);
  // bit 2 selects zero extension on loads.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // The request record carries a full-width address so it is independent of
  // the array size chosen by a particular instance.
  localparam int REQ_ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic                  write;
    logic [REQ_ADDR_W-1:0] addr;
    logic [31:0]           wdata;
    logic [2:0]            funct3;
  } mem_req_t;

  // Unshifted byte-enable mask for an access size (lane 0 based).
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      2'b10:   size_mask = 4'b1111;
      default: size_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// -----------------------------------------------------------------------------
// data_mem_responder_if
//   Load/store bus between the pipeline (master) and the data-memory
//   responder (slave).
//
//   Handshake rules (both channels): a transfer happens on a rising clock edge
//   where valid and ready are both 1. The source holds valid and its payload
//   stable until that edge; ready may be asserted independently of valid.
//   Request channel : req_valid/req_ready, payload req_write, req_addr,
//                     req_wdata, req_funct3 (master -> slave)
//   Response channel: rsp_valid/rsp_ready, payload rsp_rdata, rsp_error
//                     (slave -> master)
// -----------------------------------------------------------------------------
interface data_mem_responder_if #(
  parameter int MEM_ADDRESS_WIDTH = 9,
  parameter int DATA_WIDTH        = 32
);
  logic                         req_valid;
  logic                         req_ready;
  logic                         req_write;
  logic [MEM_ADDRESS_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0]        req_wdata;
  logic [2:0]                   req_funct3;
  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [DATA_WIDTH-1:0]        rsp_rdata;
  logic                         rsp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_funct3, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_funct3, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/load_store_align.sv
// -----------------------------------------------------------------------------
// load_store_align
//   Combinational lane steering for one 32-bit little-endian memory word.
//   Ports:
//     funct3    in  access size/sign
//     write     in  1 = store, 0 = load
//     addr_lo   in  byte offset within the word
//     wdata     in  store data (low bytes used for SB/SH)
//     raw_bytes in  the four bytes of the addressed word, lane 0 = lowest
//     byte_en   out per-lane write enables (all zero on loads or errors)
//     wr_bytes  out store data shifted into its byte lanes
//     rdata     out extended load data (zero on stores or errors)
//     error     out misaligned access or illegal funct3 for the direction
// -----------------------------------------------------------------------------
module load_store_align
  import mem_pkg::*;
(
  input  logic [2:0]       funct3,
  input  logic             write,
  input  logic [1:0]       addr_lo,
  input  logic [31:0]      wdata,
  input  logic [3:0][7:0]  raw_bytes,
  output logic [3:0]       byte_en,
  output logic [3:0][7:0]  wr_bytes,
  output logic [31:0]      rdata,
  output logic             error
);

  logic [31:0] lane;
  logic        legal_f3;
  logic        misaligned;

  always_comb begin
    byte_en    = 4'b0000;
    wr_bytes   = wdata << {addr_lo, 3'b000};
    rdata      = 32'h0;
    lane       = raw_bytes >> {addr_lo, 3'b000};
    legal_f3   = 1'b0;
    misaligned = 1'b0;

    // Stores have no unsigned variants; loads accept BU/HU as well.
    if (write) begin
      legal_f3 = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    end else begin
      legal_f3 = (funct3 == F3_B)  || (funct3 == F3_H) || (funct3 == F3_W) ||
                 (funct3 == F3_BU) || (funct3 == F3_HU);
    end

    case (funct3[1:0])
      2'b01:   misaligned = addr_lo[0];
      2'b10:   misaligned = |addr_lo;
      default: misaligned = 1'b0;
    endcase

    error = !legal_f3 || misaligned;

    if (!error) begin
      if (write) begin
        byte_en = size_mask(funct3[1:0]) << addr_lo;
      end else begin
        case (funct3)
          F3_B:    rdata = {{24{lane[7]}}, lane[7:0]};
          F3_H:    rdata = {{16{lane[15]}}, lane[15:0]};
          F3_W:    rdata = lane;
          F3_BU:   rdata = {24'h0, lane[7:0]};
          F3_HU:   rdata = {16'h0, lane[15:0]};
          default: rdata = 32'h0;
        endcase
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//   Multi-cycle data-memory target for the pipeline's load/store bus. Accepts
//   one request at a time, waits WAIT_CYCLES cycles, executes the access on
//   the edge that enters RESP, then presents the response until it is taken.
//   Ports:
//     clk       in  rising-edge clock
//     rst       in  asynchronous active-low reset
//     bus       slave modport of data_mem_responder_if (request/response)
//     busy      out state != IDLE
//     dbg_state out current FSM state
// -----------------------------------------------------------------------------
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH        = 32,
  parameter int MEM_ADDRESS_WIDTH = 9,
  parameter int WAIT_CYCLES       = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  data_mem_responder_if.slave    bus,
  output logic                   busy,
  output state_t                 dbg_state
);

  localparam int DEPTH = 1 << MEM_ADDRESS_WIDTH;
  localparam logic [3:0] LAST_WAIT = 4'(WAIT_CYCLES - 1);

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  mem_req_t                req_q;
  mem_req_t                req_in;
  mem_req_t                acc_req;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    err_q;
  logic                    accept;
  logic                    commit;

  logic [7:0]              mem_q [DEPTH];

  logic [MEM_ADDRESS_WIDTH-1:0] acc_addr;
  logic [MEM_ADDRESS_WIDTH-3:0] acc_word;
  logic [3:0][7:0]              raw_bytes;
  logic [3:0]                   al_byte_en;
  logic [3:0][7:0]              al_wr_bytes;
  logic [31:0]                  al_rdata;
  logic                         al_error;
  logic                         unused_addr_hi;

  // ---------------------------------------------------------------------------
  // Request capture and access source
  // ---------------------------------------------------------------------------
  always_comb begin
    req_in        = '0;
    req_in.write  = bus.req_write;
    req_in.addr   = REQ_ADDR_W'(bus.req_addr);
    req_in.wdata  = bus.req_wdata;
    req_in.funct3 = bus.req_funct3;
  end

  assign accept = (state_q == IDLE) && bus.req_valid;

  // With zero wait states the access executes on the acceptance edge itself,
  // before the latched copy exists, so the live request is used from IDLE.
  assign acc_req  = (state_q == IDLE) ? req_in : req_q;
  assign acc_addr = acc_req.addr[MEM_ADDRESS_WIDTH-1:0];
  assign acc_word = acc_addr[MEM_ADDRESS_WIDTH-1:2];
  assign unused_addr_hi = ^acc_req.addr[REQ_ADDR_W-1:MEM_ADDRESS_WIDTH];

  always_comb begin
    raw_bytes = '0;
    for (int k = 0; k < 4; k++) begin
      raw_bytes[k] = mem_q[{acc_word, k[1:0]}];
    end
  end

  load_store_align u_align (
    .funct3    (acc_req.funct3),
    .write     (acc_req.write),
    .addr_lo   (acc_addr[1:0]),
    .wdata     (acc_req.wdata),
    .raw_bytes (raw_bytes),
    .byte_en   (al_byte_en),
    .wr_bytes  (al_wr_bytes),
    .rdata     (al_rdata),
    .error     (al_error)
  );

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = 4'd0;
        if (bus.req_valid) begin
          state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (cnt_q == LAST_WAIT) begin
          state_d = RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // The access executes exactly once, on the edge that enters RESP. Gating
  // with rst keeps the unreset array from being written while reset is held.
  assign commit = rst && (state_d == RESP) && (state_q != RESP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        req_q <= req_in;
      end
      if (commit) begin
        rdata_q <= al_rdata;
        err_q   <= al_error;
      end
    end
  end

  // Byte array: deliberately not reset.
  always_ff @(posedge clk) begin
    if (commit && acc_req.write && !al_error) begin
      for (int k = 0; k < 4; k++) begin
        if (al_byte_en[k]) begin
          mem_q[{acc_word, k[1:0]}] <= al_wr_bytes[k];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_error = err_q;
  assign busy          = (state_q != IDLE);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//   Directed steps followed by randomized traffic against a byte-array
//   reference model of the load/store rules.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;
  import mem_pkg::*;

  localparam int WAIT_CYCLES = 2;
  localparam int AW          = 9;
  localparam logic [8:0] POKE_ADDR = 9'h014;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic   clk = 1'b0;
  logic   rst;
  logic   busy;
  state_t dbg_state;

  always #5 clk = ~clk;

  data_mem_responder_if #(.MEM_ADDRESS_WIDTH(AW), .DATA_WIDTH(32)) bus ();

  data_mem_responder #(
    .DATA_WIDTH        (32),
    .MEM_ADDRESS_WIDTH (AW),
    .WAIT_CYCLES       (WAIT_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  int tests = 0;
  int fails = 0;

  // Reference byte array (little-endian memory image).
  logic [7:0] ref_mem [1 << AW];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Scoreboard helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Access rules: size = 1 << funct3[1:0] bytes, address must be a multiple of
  // size, stores allow only funct3 0..2, loads allow 0,1,2,4,5.
  function automatic void model(input logic wr, input int a, input logic [31:0] wd,
                                input logic [2:0] f3, output logic [31:0] rd,
                                output logic er);
    int size;
    bit legal;
    size = 1 << f3[1:0];
    if (wr) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
                    (f3 == 3'd4) || (f3 == 3'd5);
    rd = 32'h0;
    er = !legal || ((a % size) != 0);
    if (er) return;
    if (wr) begin
      for (int i = 0; i < size; i++) ref_mem[a + i] = wd[8*i +: 8];
    end else begin
      for (int i = 0; i < size; i++) rd[8*i +: 8] = ref_mem[a + i];
      if (!f3[2] && size < 4 && rd[8*size-1])
        rd = rd | ~((32'h1 << (8*size)) - 32'h1);
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: one full transaction. Called with time positioned just after a
  // rising edge. stall = cycles of rsp_ready low in RESP; hold = rsp_ready kept
  // high throughout; poke = drive a stray store while the response is stalled.
  // ---------------------------------------------------------------------------
  task automatic do_txn(input logic wr, input logic [8:0] a, input logic [31:0] wd,
                        input logic [2:0] f3, input int stall, input bit hold,
                        input bit poke, output logic [31:0] rd, output logic er);
    logic [31:0] exp_rd;
    logic        exp_er;
    int          lat;
    model(wr, int'(a), wd, f3, exp_rd, exp_er);
    check("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    bus.req_funct3 = f3;
    bus.rsp_ready  = hold;
    @(posedge clk); #1;
    // Garbage after acceptance must be ignored.
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'($urandom_range(0, 1));
    bus.req_addr   = 9'($urandom);
    bus.req_wdata  = $urandom;
    bus.req_funct3 = 3'($urandom);
    check("busy_after_accept", 32'(busy), 32'd1);
    lat = 0;
    while (bus.rsp_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("rsp_latency", 32'(lat), 32'(WAIT_CYCLES));
    check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    rd = bus.rsp_rdata;
    er = bus.rsp_error;
    check("rsp_rdata_model", rd, exp_rd);
    check("rsp_error_model", 32'(er), 32'(exp_er));
    if (hold) begin
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
    end else begin
      for (int i = 0; i < stall; i++) begin
        if (poke) begin
          bus.req_valid  = 1'b1;
          bus.req_write  = 1'b1;
          bus.req_addr   = POKE_ADDR;
          bus.req_wdata  = 32'hCAFEF00D;
          bus.req_funct3 = F3_W;
        end
        @(posedge clk); #1;
        check("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("stall_rdata", bus.rsp_rdata, rd);
        check("stall_error", 32'(bus.rsp_error), 32'(er));
        check("stall_req_ready", 32'(bus.req_ready), 32'd0);
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
    end
    check("rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
    check("req_ready_back", 32'(bus.req_ready), 32'd1);
    check("state_idle", 32'(dbg_state), 32'(IDLE));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] rd;
    logic        er;

    rst            = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_funct3 = '0;
    bus.rsp_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst_rsp_error", 32'(bus.rsp_error), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b1;
    @(posedge clk); #1;

    // Word store then sub-word loads.
    do_txn(1, 9'h010, 32'hDEADBEEF, F3_W, 0, 0, 0, rd, er);
    check("sw_rdata_zero", rd, 32'h0);
    do_txn(0, 9'h010, 32'h0, F3_W, 1, 0, 0, rd, er);
    check("lw_deadbeef", rd, 32'hDEADBEEF);
    check("lw_no_error", 32'(er), 32'd0);
    do_txn(0, 9'h013, 32'h0, F3_B, 0, 0, 0, rd, er);
    check("lb_013", rd, 32'hFFFFFFDE);
    do_txn(0, 9'h013, 32'h0, F3_BU, 0, 0, 0, rd, er);
    check("lbu_013", rd, 32'h000000DE);
    do_txn(0, 9'h010, 32'h0, F3_H, 0, 0, 0, rd, er);
    check("lh_010", rd, 32'hFFFFBEEF);
    do_txn(0, 9'h012, 32'h0, F3_HU, 0, 0, 0, rd, er);
    check("lhu_012", rd, 32'h0000DEAD);

    // Byte and halfword stores.
    do_txn(1, 9'h011, 32'h12345677, F3_B, 0, 0, 0, rd, er);
    do_txn(0, 9'h010, 32'h0, F3_W, 0, 0, 0, rd, er);
    check("lw_after_sb", rd, 32'hDEAD77EF);
    do_txn(1, 9'h012, 32'hAAAA0001, F3_H, 0, 0, 0, rd, er);
    do_txn(0, 9'h010, 32'h0, F3_W, 0, 0, 0, rd, er);
    check("lw_after_sh", rd, 32'h000177EF);

    // Errors.
    do_txn(0, 9'h012, 32'h0, F3_W, 0, 0, 0, rd, er);
    check("lw_mis_error", 32'(er), 32'd1);
    check("lw_mis_rdata", rd, 32'h0);
    do_txn(1, 9'h011, 32'h0000BBBB, F3_H, 0, 0, 0, rd, er);
    check("sh_mis_error", 32'(er), 32'd1);
    do_txn(0, 9'h010, 32'h0, F3_W, 0, 0, 0, rd, er);
    check("lw_after_bad_sh", rd, 32'h000177EF);
    do_txn(0, 9'h010, 32'h0, 3'b011, 0, 0, 0, rd, er);
    check("ld_f3_011_error", 32'(er), 32'd1);
    do_txn(1, 9'h010, 32'h0, F3_BU, 0, 0, 0, rd, er);
    check("st_f3_100_error", 32'(er), 32'd1);

    // rsp_ready held high: response still lasts one cycle.
    do_txn(0, 9'h010, 32'h0, F3_W, 0, 1, 0, rd, er);
    check("hold_ready_lw", rd, 32'h000177EF);

    // Backpressure with a stray request during the stall.
    do_txn(1, POKE_ADDR, 32'h01234567, F3_W, 0, 0, 0, rd, er);
    do_txn(0, 9'h010, 32'h0, F3_W, 5, 0, 1, rd, er);
    check("bp_lw", rd, 32'h000177EF);
    do_txn(0, POKE_ADDR, 32'h0, F3_W, 0, 0, 0, rd, er);
    check("poke_ignored", rd, 32'h01234567);

    // Reset while a store waits.
    do_txn(1, 9'h020, 32'h0, F3_W, 0, 0, 0, rd, er);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_addr   = 9'h020;
    bus.req_wdata  = 32'h00000055;
    bus.req_funct3 = F3_W;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_wait", 32'(dbg_state), 32'(WAIT));
    rst = 1'b0;
    #1;
    check("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    do_txn(0, 9'h020, 32'h0, F3_W, 0, 0, 0, rd, er);
    check("no_55_written", rd, 32'h0);
    do_txn(1, 9'h020, 32'h00000011, F3_W, 0, 0, 0, rd, er);
    do_txn(0, 9'h020, 32'h0, F3_W, 0, 0, 0, rd, er);
    check("lw_after_rst", rd, 32'h00000011);

    // Fill the whole array, then random traffic against the model.
    for (int w = 0; w < (1 << AW) / 4; w++) begin
      do_txn(1, 9'(w * 4), $urandom, F3_W, 0, 0, 0, rd, er);
    end
    for (int n = 0; n < 200; n++) begin
      do_txn(1'($urandom_range(0, 1)), 9'($urandom), $urandom,
             3'($urandom_range(0, 7)), $urandom_range(0, 3),
             ($urandom_range(0, 4) == 0), 0, rd, er);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
